// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
// No logic here; imported by the arbiter top.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic REQ0       = 1'b0;
  localparam logic REQ1       = 1'b1;
  localparam int   BEAT_CNT_W = 4;

endpackage

// File: rtl/mux_bus_arbiter_mux_2_1.sv
// 8-bit 2:1 datapath multiplexer, purely combinational (zero latency).
// No flow control; the arbiter owns the select.
module mux_2_1 (
  input  logic       sel,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic [7:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin burst arbiter sharing one 8-bit mux; ARB_BURST_LIMIT_EN caps beats per grant.
// Request to grant 1 edge, grant to first data_valid 1 edge, then 1 beat/cycle.
// Ungranted requester simply waits; it is only seen at arbitration and end-of-burst.
module mux_bus_arbiter
  import mux_arb_pkg::*;
#(
  parameter logic RESET_PRIO = 1'b0,
  parameter int   MAX_BURST  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       last0,
  input  logic       last1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       owner,
  output logic       busy
);

  arb_state_t state;
  logic       prio;
  logic [7:0] mux_dat;
  logic       cur;
  logic       cur_req;
  logic       cur_last;
  logic       oth_req;
  logic       limit_hit;
  logic       burst_end;
  logic       in_grant;
  logic       nxt_grant_vld;
  logic       nxt_grant;

  mux_2_1 u_mux (
    .sel (sel),
    .in0 (data0),
    .in1 (data1),
    .out (mux_dat)
  );

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [BEAT_CNT_W-1:0] BURST_LIM = BEAT_CNT_W'(MAX_BURST);
  logic [BEAT_CNT_W-1:0] beat_cnt;

  // Counts beats already accepted in this grant; the beat reaching the limit closes it.
  assign limit_hit = (beat_cnt + 1'b1) == BURST_LIM;
`else
  assign limit_hit = 1'b0;
`endif

  assign in_grant = (state != IDLE);

  always_comb begin
    cur       = (state == GRANT1) ? REQ1 : REQ0;
    cur_req   = cur ? req1  : req0;
    cur_last  = cur ? last1 : last0;
    oth_req   = cur ? req0  : req1;
    burst_end = !cur_req || cur_last || limit_hit;
    nxt_grant_vld = 1'b0;
    nxt_grant     = REQ0;
    if (!in_grant) begin
      nxt_grant_vld = req0 || req1;
      nxt_grant     = (req0 && req1) ? prio : req1;
    end else if (burst_end && oth_req) begin
      // Back-to-back handover: no idle bubble between bursts.
      nxt_grant_vld = 1'b1;
      nxt_grant     = ~cur;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prio       <= RESET_PRIO;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      beat_cnt   <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (in_grant && cur_req) begin
        data_out   <= mux_dat;
        owner      <= cur;
        data_valid <= 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        beat_cnt   <= beat_cnt + 1'b1;
`endif
      end
      if (in_grant && burst_end) begin
        prio <= ~cur;
      end
      if (nxt_grant_vld) begin
        state <= nxt_grant ? GRANT1 : GRANT0;
        gnt0  <= ~nxt_grant;
        gnt1  <= nxt_grant;
        sel   <= nxt_grant;
        busy  <= 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        beat_cnt <= '0;
`endif
      end else if (in_grant && burst_end) begin
        state <= IDLE;
        gnt0  <= 1'b0;
        gnt1  <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

endmodule
